// File: rtl/windowed_register_file.sv
// Windowed integer register file with integrated icc register.
// Operands A/B feed the ALU combinationally; the ALU result is written back on rd.
// CWP moves on SAVE/RESTORE unless the target window is marked invalid in WIM,
// in which case a one-cycle overflow/underflow trap pulse is raised instead.
module windowed_register_file #(
    parameter int NWINDOWS = 4,
    parameter int WIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [4:0]                  ra_addr,
    input  logic [4:0]                  rb_addr,
    output logic [WIDTH-1:0]            ra_data,
    output logic [WIDTH-1:0]            rb_data,
    input  logic                        rd_we,
    input  logic [4:0]                  rd_addr,
    input  logic [WIDTH-1:0]            rd_data,
    input  logic                        save,
    input  logic                        restore,
    input  logic                        wim_we,
    input  logic [NWINDOWS-1:0]         wim_in,
    input  logic                        cc_we,
    input  logic                        n_in,
    input  logic                        z_in,
    input  logic                        c_in,
    input  logic                        v_in,
    output logic [3:0]                  icc,
    output logic                        ci,
    output logic [$clog2(NWINDOWS)-1:0] cwp,
    output logic [NWINDOWS-1:0]         wim,
    output logic                        window_overflow,
    output logic                        window_underflow
);

    localparam int CWPW  = $clog2(NWINDOWS);
    localparam int NREGS = 8 + 16 * NWINDOWS;
    localparam int PW    = $clog2(NREGS);

    // Physical layout: slots 0..7 are the globals, slot 8 onwards holds the
    // windows back to back, 16 registers each (8 outs followed by 8 locals).
    logic [WIDTH-1:0] regs [NREGS];

    logic [CWPW-1:0] cwp_dec;
    logic [CWPW-1:0] cwp_inc;
    logic [CWPW-1:0] cwp_nxt;
    logic            ovf_nxt;
    logic            unf_nxt;

    // Ins of window w are the outs of window w+1, so they index the next window's
    // block with the out offset. Outs/locals offset is {a[4], a[2:0]}: r8->0, r23->15.
    function automatic logic [PW-1:0] phys(input logic [4:0] a, input logic [CWPW-1:0] w);
        logic [CWPW-1:0] w_up;
        logic [PW-1:0]   idx;
        w_up = w + CWPW'(1);
        if (a[4:3] == 2'b00) begin
            idx = PW'(a[2:0]);
        end else if (a[4:3] == 2'b11) begin
            idx = PW'(8) + PW'({w_up, 1'b0, a[2:0]});
        end else begin
            idx = PW'(8) + PW'({w, a[4], a[2:0]});
        end
        return idx;
    endfunction

    assign ra_data = (ra_addr == 5'd0) ? '0 : regs[phys(ra_addr, cwp)];
    assign rb_data = (rb_addr == 5'd0) ? '0 : regs[phys(rb_addr, cwp)];
    assign ci      = icc[1];

    // Decide the window move or trap; simultaneous save+restore is a no-op.
    always_comb begin
        cwp_dec = cwp - CWPW'(1);
        cwp_inc = cwp + CWPW'(1);
        cwp_nxt = cwp;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        if (save && !restore) begin
            if (wim[cwp_dec]) ovf_nxt = 1'b1;
            else              cwp_nxt = cwp_dec;
        end else if (restore && !save) begin
            if (wim[cwp_inc]) unf_nxt = 1'b1;
            else              cwp_nxt = cwp_inc;
        end
    end

    // Register array write-back, addressed through the pre-edge window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (rd_we && (rd_addr != 5'd0)) begin
            regs[phys(rd_addr, cwp)] <= rd_data;
        end
    end

    // Window pointer, WIM, condition codes and trap pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cwp              <= CWPW'(NWINDOWS - 1);
            wim              <= NWINDOWS'(1);
            icc              <= 4'b0000;
            window_overflow  <= 1'b0;
            window_underflow <= 1'b0;
        end else begin
            cwp              <= cwp_nxt;
            window_overflow  <= ovf_nxt;
            window_underflow <= unf_nxt;
            if (wim_we) wim <= wim_in;
            if (cc_we)  icc <= {n_in, z_in, c_in, v_in};
        end
    end

endmodule

// File: tb/tb_windowed_register_file.sv
// Directed bench for windowed_register_file with an array-based reference model
// checked every negative clock edge plus hand-computed literal expectations.
module tb_windowed_register_file;

    localparam int NW = 4;
    localparam int W  = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    ra_addr, rb_addr, rd_addr;
    logic [W-1:0]  ra_data, rb_data, rd_data;
    logic          rd_we, save, restore, wim_we, cc_we;
    logic [NW-1:0] wim_in, wim;
    logic          n_in, z_in, c_in, v_in;
    logic [3:0]    icc;
    logic          ci;
    logic [1:0]    cwp;
    logic          window_overflow, window_underflow;

    int checks = 0;
    int errors = 0;

    windowed_register_file #(.NWINDOWS(NW), .WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_data), .rb_data(rb_data),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
        .save(save), .restore(restore),
        .wim_we(wim_we), .wim_in(wim_in),
        .cc_we(cc_we), .n_in(n_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
        .icc(icc), .ci(ci), .cwp(cwp), .wim(wim),
        .window_overflow(window_overflow), .window_underflow(window_underflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [W-1:0] glob_m [8];
    logic [W-1:0] win_m  [16*NW];
    int           cwp_m;
    logic [NW-1:0] wim_m;
    logic [3:0]   icc_m;
    bit           ov_m, un_m;

    function automatic int win_idx(int r, int w);
        if (r < 24) return 16*w + (r - 8);
        return 16*((w + 1) % NW) + (r - 24);
    endfunction

    function automatic logic [W-1:0] m_read(int r);
        if (r == 0) return '0;
        if (r < 8)  return glob_m[r];
        return win_m[win_idx(r, cwp_m)];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: apply the architectural rules at each edge using pre-edge state.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) glob_m[i] = '0;
            for (int i = 0; i < 16*NW; i++) win_m[i] = '0;
            cwp_m = NW - 1;
            wim_m = 1;
            icc_m = 0;
            ov_m  = 0;
            un_m  = 0;
        end else begin
            int a, nxt;
            a = int'(rd_addr);
            if (rd_we && a != 0) begin
                if (a < 8) glob_m[a] = rd_data;
                else       win_m[win_idx(a, cwp_m)] = rd_data;
            end
            ov_m = 0;
            un_m = 0;
            if (save && !restore) begin
                nxt = (cwp_m + NW - 1) % NW;
                if (wim_m[nxt]) ov_m = 1; else cwp_m = nxt;
            end else if (restore && !save) begin
                nxt = (cwp_m + 1) % NW;
                if (wim_m[nxt]) un_m = 1; else cwp_m = nxt;
            end
            if (wim_we) wim_m = wim_in;
            if (cc_we)  icc_m = {n_in, z_in, c_in, v_in};
        end
    end

    // Compare all outputs against the model every cycle.
    always @(negedge clk) begin
        check("ra_data", ra_data, m_read(int'(ra_addr)));
        check("rb_data", rb_data, m_read(int'(rb_addr)));
        check("cwp", 32'(cwp), 32'(cwp_m));
        check("wim", 32'(wim), 32'(wim_m));
        check("icc", 32'(icc), 32'(icc_m));
        check("ci", 32'(ci), 32'(icc_m[1]));
        check("overflow", 32'(window_overflow), 32'(ov_m));
        check("underflow", 32'(window_underflow), 32'(un_m));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        rd_we = 1'b1; rd_addr = a; rd_data = d;
        tick();
        rd_we = 1'b0;
    endtask

    task automatic do_op(input logic s, input logic r);
        save = s; restore = r;
        tick();
        save = 1'b0; restore = 1'b0;
    endtask

    task automatic load_wim(input logic [NW-1:0] v);
        wim_we = 1'b1; wim_in = v;
        tick();
        wim_we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        ra_addr = a;
        #1;
        check(name, ra_data, exp);
    endtask

    initial begin
        reset = 1'b1;
        ra_addr = '0; rb_addr = '0; rd_addr = '0; rd_data = '0;
        rd_we = 0; save = 0; restore = 0; wim_we = 0; wim_in = '0;
        cc_we = 0; n_in = 0; z_in = 0; c_in = 0; v_in = 0;
        repeat (2) tick();
        reset = 1'b0;

        // Reset state
        for (int a = 0; a < 32; a++) begin
            ra_addr = 5'(a); rb_addr = 5'(31 - a);
            #1;
            check("reset_ra", ra_data, 32'h0);
            check("reset_rb", rb_data, 32'h0);
        end
        check("reset_cwp", 32'(cwp), 32'd3);
        check("reset_wim", 32'(wim), 32'h1);
        check("reset_icc", 32'(icc), 32'h0);
        check("reset_traps", 32'({window_overflow, window_underflow}), 32'h0);

        // Writes at cwp=3
        write_reg(5'd1, 32'h11);
        write_reg(5'd9, 32'hA5);
        write_reg(5'd17, 32'h5A);
        write_reg(5'd0, 32'hFF);
        rd_chk("r0_zero", 5'd0, 32'h0);
        rd_chk("r1", 5'd1, 32'h11);
        rd_chk("r9", 5'd9, 32'hA5);
        rd_chk("r17", 5'd17, 32'h5A);

        // SAVE: outs become ins
        do_op(1'b1, 1'b0);
        check("save_cwp", 32'(cwp), 32'd2);
        rd_chk("r25_after_save", 5'd25, 32'hA5);
        rd_chk("r17_after_save", 5'd17, 32'h0);
        rd_chk("r1_after_save", 5'd1, 32'h11);
        do_op(1'b0, 1'b1);
        check("restore_cwp", 32'(cwp), 32'd3);
        rd_chk("r17_after_restore", 5'd17, 32'h5A);

        // Overflow against wim=0001
        do_op(1'b1, 1'b0);
        do_op(1'b1, 1'b0);
        check("cwp_1", 32'(cwp), 32'd1);
        do_op(1'b1, 1'b0);
        check("ovf_pulse", 32'(window_overflow), 32'd1);
        check("ovf_cwp_held", 32'(cwp), 32'd1);
        tick();
        check("ovf_clear", 32'(window_overflow), 32'd0);

        // Wrap-around in both directions
        load_wim(4'b1000);
        do_op(1'b1, 1'b0);
        check("cwp_0", 32'(cwp), 32'd0);
        load_wim(4'b0100);
        do_op(1'b1, 1'b0);
        check("wrap_save_cwp", 32'(cwp), 32'd3);
        check("wrap_no_trap", 32'(window_overflow), 32'd0);
        do_op(1'b0, 1'b1);
        check("wrap_restore_cwp", 32'(cwp), 32'd0);
        do_op(1'b1, 1'b0);
        do_op(1'b1, 1'b0);
        check("ovf2_pulse", 32'(window_overflow), 32'd1);

        // Underflow from cwp=2 with wim=1000
        load_wim(4'b1000);
        do_op(1'b1, 1'b0);
        check("cwp_2", 32'(cwp), 32'd2);
        do_op(1'b0, 1'b1);
        check("unf_pulse", 32'(window_underflow), 32'd1);
        check("unf_cwp_held", 32'(cwp), 32'd2);
        do_op(1'b1, 1'b1);
        check("both_cwp", 32'(cwp), 32'd2);
        check("both_no_trap", 32'({window_overflow, window_underflow}), 32'h0);

        // SAVE with simultaneous WIM load uses the old WIM
        wim_we = 1'b1; wim_in = 4'b0010;
        do_op(1'b1, 1'b0);
        wim_we = 1'b0;
        check("old_wim_cwp", 32'(cwp), 32'd1);
        check("old_wim_no_trap", 32'(window_overflow), 32'd0);

        // Read-during-write returns the old value
        load_wim(4'b0000);
        do_op(1'b0, 1'b1);
        do_op(1'b0, 1'b1);
        check("cwp_back_3", 32'(cwp), 32'd3);
        ra_addr = 5'd9; rd_we = 1'b1; rd_addr = 5'd9; rd_data = 32'h77;
        #1;
        check("rdw_old", ra_data, 32'hA5);
        tick();
        rd_we = 1'b0;
        #1;
        check("rdw_new", ra_data, 32'h77);

        // icc path
        cc_we = 1'b1; {n_in, z_in, c_in, v_in} = 4'b1011;
        tick();
        cc_we = 1'b0; {n_in, z_in, c_in, v_in} = 4'b0100;
        check("icc_load", 32'(icc), 32'hB);
        check("ci_load", 32'(ci), 32'd1);
        tick();
        tick();
        check("icc_hold", 32'(icc), 32'hB);

        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        #1;
        check("async_icc", 32'(icc), 32'h0);
        check("async_ci", 32'(ci), 32'd0);
        check("async_cwp", 32'(cwp), 32'd3);
        check("async_wim", 32'(wim), 32'h1);
        rd_we = 1'b1; rd_addr = 5'd2; rd_data = 32'hDEAD;
        tick();
        rd_we = 1'b0;
        reset = 1'b0;
        rd_chk("post_reset_r1", 5'd1, 32'h0);
        rd_chk("post_reset_r2", 5'd2, 32'h0);
        rd_chk("post_reset_r9", 5'd9, 32'h0);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
